// File: rtl/mips16_pkg.sv
// Shared constants and types for the 16-bit MIPS multiply/divide datapath.
package mips16_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the register file/control unit and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic [1:0]       hilo_we;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, rs, rt, hilo_we, write_data,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, rs, rt, hilo_we, write_data,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/sign_magnitude.sv
// Two's-complement to sign/magnitude conversion; passes the value through when signed_i is low.
module sign_magnitude #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             signed_i,
    output logic [WIDTH-1:0] mag_o,
    output logic             sign_o
);
    assign sign_o = signed_i & value_i[WIDTH-1];
    assign mag_o  = sign_o ? ({WIDTH{1'b0}} - value_i) : value_i;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider writing the architectural HI/LO registers.
// Define MULDIV_SIGNED_EN to make op 10/11 signed; otherwise op[1] is ignored.
module mult_div_unit
    import mips16_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input logic            clock,
    input logic            reset_n,
    mult_div_unit_if.slave bus
);
    localparam int unsigned W2 = 2 * WIDTH;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W2-1:0]    acc_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic             neg_q;
    logic             rem_neg_q;

    logic             is_div;
    logic             is_idle;
    logic             signed_op;
    logic             sign_rs;
    logic             sign_rt;
    logic [WIDTH-1:0] mag_rs;
    logic [WIDTH-1:0] mag_rt;

    assign is_div  = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    assign is_idle = (state_q == ST_IDLE) || (state_q == ST_DONE);

`ifdef MULDIV_SIGNED_EN
    assign signed_op = bus.op[1];

    sign_magnitude #(.WIDTH(WIDTH)) u_abs_rs (
        .value_i  (bus.rs),
        .signed_i (signed_op),
        .mag_o    (mag_rs),
        .sign_o   (sign_rs)
    );

    sign_magnitude #(.WIDTH(WIDTH)) u_abs_rt (
        .value_i  (bus.rt),
        .signed_i (signed_op),
        .mag_o    (mag_rt),
        .sign_o   (sign_rt)
    );
`else
    assign signed_op = 1'b0;
    assign sign_rs   = 1'b0;
    assign sign_rt   = 1'b0;
    assign mag_rs    = bus.rs;
    assign mag_rt    = bus.rt;
`endif

    // One adder/subtractor serves both iterations; the divide path uses its borrow bit.
    logic [WIDTH+1:0] add_a;
    logic [WIDTH+1:0] add_b;
    logic [WIDTH+1:0] add_sum;
    logic [W2-1:0]    acc_step;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    always_comb begin
        add_b = {2'b00, dvsr_q};
        if (state_q == ST_DIV) begin
            add_a    = {1'b0, acc_q[W2-1:WIDTH-1]};
            add_sum  = add_a - add_b;
            acc_step = add_sum[WIDTH+1] ? {acc_q[W2-2:0], 1'b0}
                                        : {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            add_a    = {2'b00, acc_q[W2-1:WIDTH]};
            add_sum  = add_a + add_b;
            acc_step = acc_q[0] ? {add_sum[WIDTH:0], acc_q[WIDTH-1:1]}
                                : {1'b0, acc_q[W2-1:1]};
        end

        prod = neg_q ? ({W2{1'b0}} - acc_step) : acc_step;
        quot = neg_q ? ({WIDTH{1'b0}} - acc_step[WIDTH-1:0]) : acc_step[WIDTH-1:0];
        rem  = rem_neg_q ? ({WIDTH{1'b0}} - acc_step[W2-1:WIDTH]) : acc_step[W2-1:WIDTH];

        if (state_q == ST_DIV) begin
            res_hi = rem;
            res_lo = quot;
        end else begin
            res_hi = prod[W2-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            dvsr_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    if (bus.start) begin
                        cnt_q     <= CNT_W'(WIDTH);
                        dvsr_q    <= mag_rt;
                        acc_q     <= {{WIDTH{1'b0}}, mag_rs};
                        neg_q     <= signed_op & (sign_rs ^ sign_rt);
                        rem_neg_q <= signed_op & sign_rs;
                        if (is_div && (bus.rt == '0)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            hi_q    <= bus.rs;
                            lo_q    <= '1;
                        end else begin
                            state_q <= is_div ? ST_DIV : ST_MUL;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        if (bus.hilo_we[1]) hi_q <= bus.write_data;
                        if (bus.hilo_we[0]) lo_q <= bus.write_data;
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; honours MULDIV_SIGNED_EN for op 10/11.
module tb_mult_div_unit;
    import mips16_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mult_div_unit_if #(.WIDTH(16)) bus ();

    mult_div_unit #(.WIDTH(16), .CNT_W(5)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait for done; operand inputs are scrambled after the start edge.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int busy_cycles, output bit got_done);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        tick();
        bus.start = 1'b0;
        bus.rs    = 16'hDEAD;
        bus.rt    = 16'hBEEF;
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.div_by_zero});
        end
        checks++;
        if ({bus.hi, bus.lo} !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo got %h want 00000000", {bus.hi, bus.lo});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_hilo_write();
        int bc;
        bit gd;
        bus.hilo_we    = 2'b11;
        bus.write_data = 16'hABCD;
        tick();
        bus.hilo_we = 2'b00;
        checks++;
        if ({bus.hi, bus.lo} !== 32'hABCD_ABCD) begin
            errors++;
            $display("FAIL mthi_mtlo got %h want abcdabcd", {bus.hi, bus.lo});
        end
        bus.hilo_we    = 2'b10;
        bus.write_data = 16'h1111;
        tick();
        bus.hilo_we = 2'b00;
        checks++;
        if ({bus.hi, bus.lo} !== 32'h1111_ABCD) begin
            errors++;
            $display("FAIL mthi_only got %h want 1111abcd", {bus.hi, bus.lo});
        end
        // start wins over a same-cycle write
        bus.hilo_we    = 2'b11;
        bus.write_data = 16'h5555;
        bus.start      = 1'b1;
        bus.op         = OP_MULTU;
        bus.rs         = 16'd3;
        bus.rt         = 16'd4;
        tick();
        bus.start   = 1'b0;
        bus.hilo_we = 2'b00;
        checks++;
        if ({bus.busy, bus.hi, bus.lo} !== {1'b1, 32'h1111_ABCD}) begin
            errors++;
            $display("FAIL start_vs_write got %b %h want 1 1111abcd", bus.busy, {bus.hi, bus.lo});
        end
        // ignored while busy
        bus.hilo_we    = 2'b11;
        bus.write_data = 16'h7777;
        bc = 0;
        gd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                gd = 1'b1;
                break;
            end
            tick();
        end
        bus.hilo_we = 2'b00;
        checks++;
        if (!gd || {bus.hi, bus.lo} !== 32'h0000_000C) begin
            errors++;
            $display("FAIL write_busy_ignored got done=%b %h want 1 0000000c", gd, {bus.hi, bus.lo});
        end
        tick();
    endtask

    task automatic test_multu();
        int bc;
        bit gd;
        run_op(OP_MULTU, 16'hFFFF, 16'hFFFF, bc, gd);
        checks++;
        if (!gd || bc != 16) begin
            errors++;
            $display("FAIL multu_latency got done=%b busy=%0d want 1 16", gd, bc);
        end
        checks++;
        if ({bus.hi, bus.lo, bus.div_by_zero} !== {32'hFFFE_0001, 1'b0}) begin
            errors++;
            $display("FAIL multu_ffff got %h dbz=%b want fffe0001 0", {bus.hi, bus.lo}, bus.div_by_zero);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle got %b want 0", bus.done);
        end
        tick();
        tick();
        checks++;
        if ({bus.hi, bus.lo} !== 32'hFFFE_0001) begin
            errors++;
            $display("FAIL hilo_hold got %h want fffe0001", {bus.hi, bus.lo});
        end
    endtask

    task automatic test_divu();
        int bc;
        bit gd;
        run_op(OP_DIVU, 16'd100, 16'd7, bc, gd);
        checks++;
        if (!gd || bc != 16) begin
            errors++;
            $display("FAIL divu_latency got done=%b busy=%0d want 1 16", gd, bc);
        end
        checks++;
        if ({bus.hi, bus.lo, bus.div_by_zero} !== {16'd2, 16'd14, 1'b0}) begin
            errors++;
            $display("FAIL divu_100_7 got %h dbz=%b want 0002000e 0", {bus.hi, bus.lo}, bus.div_by_zero);
        end
        run_op(OP_DIVU, 16'd5, 16'd7, bc, gd);
        checks++;
        if (!gd || {bus.hi, bus.lo} !== 32'h0005_0000) begin
            errors++;
            $display("FAIL divu_small got done=%b %h want 1 00050000", gd, {bus.hi, bus.lo});
        end
        tick();
    endtask

    task automatic test_div_by_zero();
        int bc;
        bit gd;
        run_op(OP_DIVU, 16'h1234, 16'h0000, bc, gd);
        checks++;
        if (!gd || bc != 0) begin
            errors++;
            $display("FAIL dbz_latency got done=%b busy=%0d want 1 0", gd, bc);
        end
        checks++;
        if ({bus.hi, bus.lo, bus.div_by_zero, bus.busy} !== {32'h1234_FFFF, 2'b10}) begin
            errors++;
            $display("FAIL dbz_result got %h dbz=%b busy=%b want 1234ffff 1 0",
                     {bus.hi, bus.lo}, bus.div_by_zero, bus.busy);
        end
        tick();
        checks++;
        if ({bus.done, bus.div_by_zero} !== 2'b00) begin
            errors++;
            $display("FAIL dbz_clear got %b want 00", {bus.done, bus.div_by_zero});
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        bit gd;
        run_op(OP_MULTU, 16'h0000, 16'h1234, bc, gd);
        checks++;
        if (!gd || {bus.hi, bus.lo} !== 32'h0) begin
            errors++;
            $display("FAIL multu_zero got done=%b %h want 1 00000000", gd, {bus.hi, bus.lo});
        end
        // issued during the DONE cycle
        run_op(OP_DIVU, 16'hFFFF, 16'h0010, bc, gd);
        checks++;
        if (!gd || bc != 16 || {bus.hi, bus.lo} !== 32'h000F_0FFF) begin
            errors++;
            $display("FAIL b2b_divu got done=%b busy=%0d %h want 1 16 000f0fff", gd, bc,
                     {bus.hi, bus.lo});
        end
        tick();
    endtask

    task automatic test_signed_ops();
        int bc;
        bit gd;
`ifdef MULDIV_SIGNED_EN
        run_op(OP_MULT, 16'hFFFD, 16'd5, bc, gd);
        checks++;
        if (!gd || {bus.hi, bus.lo} !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL mult_signed got done=%b %h want 1 fffffff1", gd, {bus.hi, bus.lo});
        end
        run_op(OP_DIV, 16'hFFF9, 16'd2, bc, gd);
        checks++;
        if (!gd || {bus.hi, bus.lo} !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_signed got done=%b %h want 1 fffffffd", gd, {bus.hi, bus.lo});
        end
        run_op(OP_DIV, 16'h8000, 16'hFFFF, bc, gd);
        checks++;
        if (!gd || {bus.hi, bus.lo} !== 32'h0000_8000) begin
            errors++;
            $display("FAIL div_wrap got done=%b %h want 1 00008000", gd, {bus.hi, bus.lo});
        end
`else
        run_op(OP_MULT, 16'hFFFD, 16'd5, bc, gd);
        checks++;
        if (!gd || {bus.hi, bus.lo} !== 32'h0004_FFF1) begin
            errors++;
            $display("FAIL mult_as_multu got done=%b %h want 1 0004fff1", gd, {bus.hi, bus.lo});
        end
        run_op(OP_DIV, 16'hFFF9, 16'd2, bc, gd);
        checks++;
        if (!gd || {bus.hi, bus.lo} !== 32'h0001_7FFC) begin
            errors++;
            $display("FAIL div_as_divu got done=%b %h want 1 00017ffc", gd, {bus.hi, bus.lo});
        end
`endif
        tick();
    endtask

    task automatic test_abort();
        int seen_done;
        int seen_busy;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.rs    = 16'h1234;
        bus.rt    = 16'h5678;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.rs    = 16'h0001;
        bus.rt    = 16'h0000;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            errors++;
            $display("FAIL start_while_busy got busy/done %b want 10", {bus.busy, bus.done});
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 34'h0) begin
            errors++;
            $display("FAIL abort_reset got busy=%b done=%b %h want 0 0 00000000",
                     bus.busy, bus.done, {bus.hi, bus.lo});
        end
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done) seen_done++;
            if (bus.busy) seen_busy++;
        end
        checks++;
        if (seen_done != 0 || seen_busy != 0 || {bus.hi, bus.lo} !== 32'h0) begin
            errors++;
            $display("FAIL abort_quiet got done=%0d busy=%0d %h want 0 0 00000000",
                     seen_done, seen_busy, {bus.hi, bus.lo});
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.op         = OP_MULTU;
        bus.rs         = '0;
        bus.rt         = '0;
        bus.hilo_we    = 2'b00;
        bus.write_data = '0;
        test_reset();
        test_hilo_write();
        test_multu();
        test_divu();
        test_div_by_zero();
        test_back_to_back();
        test_signed_ops();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
